pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_gen_if.sv | 35 +++
 rtl/pc_next_mux.sv | 30 +++
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: FSM states and default parameters.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } pc_state_e;

  localparam int          DEF_INC          = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bus of pc_gen: control-flow inputs, imem handshake and decode PC.
// The misalign flag only exists when PC_MISALIGN_TRAP_EN is defined.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vec;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_d;
    logic            pc_d_valid;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign;
`endif

    modport master (
        input  stall, redirect_valid, redirect_pc, trap_valid, trap_vec, imem_req_ready,
`ifdef PC_MISALIGN_TRAP_EN
        output misalign,
`endif
        output imem_req_valid, pc_out, pc_d, pc_d_valid
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, trap_valid, trap_vec, imem_req_ready,
`ifdef PC_MISALIGN_TRAP_EN
        input  misalign,
`endif
        input  imem_req_valid, pc_out, pc_d, pc_d_valid
    );
endinterface

// File: rtl/pc_next_mux.sv
// Priority next-PC select: trap > redirect > sequential advance > hold.
// Without PC_MISALIGN_TRAP_EN, control-flow targets are forced word aligned.
module pc_next_mux #(
    parameter int XLEN = 32,
    parameter int INC  = 4
) (
    input  logic            trap_sel_i,
    input  logic            redir_sel_i,
    input  logic            adv_sel_i,
    input  logic [XLEN-1:0] cur_pc_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] nxt_pc_o
);
`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = '1;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
`endif

    always_comb begin
        nxt_pc_o = cur_pc_i;
        if (trap_sel_i)
            nxt_pc_o = trap_vec_i & ALIGN_MASK;
        else if (redir_sel_i)
            nxt_pc_o = redirect_pc_i & ALIGN_MASK;
        else if (adv_sel_i)
            nxt_pc_o = cur_pc_i + XLEN'(INC);
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with BOOT/RUN/WAIT handshake FSM and decode-stage PC register.
// Optional feature macro: PC_MISALIGN_TRAP_EN (flag misaligned redirects instead of aligning).
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              INC          = DEF_INC
) (
    input logic      clk,
    input logic      rst,
    pc_gen_if.master bus
);
    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] dec_pc_q, dec_pc_d;
    logic            dec_vld_q, dec_vld_d;
    logic            live, req_vld, acc, trap_take, redir_seen, mis_take, redir_take, flush;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign_q;
`endif

    always_comb begin
        live       = (state_q != BOOT);
        req_vld    = (state_q == WAIT) || (state_q == RUN && !bus.stall);
        acc        = req_vld && bus.imem_req_ready;
        trap_take  = live && bus.trap_valid;
        redir_seen = live && !bus.trap_valid && bus.redirect_valid;
`ifdef PC_MISALIGN_TRAP_EN
        mis_take   = redir_seen && (bus.redirect_pc[1:0] != 2'b00);
`else
        mis_take   = 1'b0;
`endif
        redir_take = redir_seen && !mis_take;
        // A misaligned redirect still flushes decode and abandons the request.
        flush      = trap_take || redir_seen;

        state_d = state_q;
        unique case (state_q)
            BOOT:      state_d = RUN;
            RUN, WAIT: begin
                if (flush || acc) state_d = RUN;
                else if (req_vld) state_d = WAIT;
            end
            default:   state_d = BOOT;
        endcase

        dec_pc_d  = dec_pc_q;
        dec_vld_d = dec_vld_q;
        if (flush) begin
            dec_vld_d = 1'b0;
        end else if (!bus.stall) begin
            if (acc) begin
                dec_pc_d  = fetch_pc_q;
                dec_vld_d = 1'b1;
            end else begin
                dec_vld_d = 1'b0;
            end
        end
    end

    pc_next_mux #(.XLEN(XLEN), .INC(INC)) u_next_mux (
        .trap_sel_i   (trap_take),
        .redir_sel_i  (redir_take),
        .adv_sel_i    (acc && !flush),
        .cur_pc_i     (fetch_pc_q),
        .trap_vec_i   (bus.trap_vec),
        .redirect_pc_i(bus.redirect_pc),
        .nxt_pc_o     (fetch_pc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_VECTOR;
            dec_pc_q   <= '0;
            dec_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            dec_pc_q   <= dec_pc_d;
            dec_vld_q  <= dec_vld_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= mis_take;
    end
    assign bus.misalign = misalign_q;
`endif

    assign bus.imem_req_valid = req_vld;
    assign bus.pc_out         = fetch_pc_q;
    assign bus.pc_d           = dec_pc_q;
    assign bus.pc_d_valid     = dec_vld_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed + randomized bench for pc_gen against a behavioural fetch model.
// Handles both builds of PC_MISALIGN_TRAP_EN.
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) bus ();
    pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .INC(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Model: "booted" = one cycle passed since reset, "pend" = request offered but not taken.
    logic [31:0] m_pc, m_dpc;
    bit m_dvld, m_mis, m_booted, m_pend, m_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fix(input logic [31:0] a);
`ifdef PC_MISALIGN_TRAP_EN
        return a;
`else
        return a & ~32'd3;
`endif
    endfunction

    function automatic bit m_valid();
        return m_booted && (m_pend || !bus.stall);
    endfunction

    task automatic model_edge();
        bit v, a;
        logic [31:0] old_pc;
        if (rst) begin
            m_pc = RV; m_dpc = 0; m_dvld = 0; m_mis = 0;
            m_booted = 0; m_pend = 0; m_known = 1;
            return;
        end
        m_mis = 0;
        if (!m_booted) begin
            m_booted = 1;
            if (!bus.stall) m_dvld = 0;
            return;
        end
        v = m_valid();
        a = v && bus.imem_req_ready;
        old_pc = m_pc;
        if (bus.trap_valid) begin
            m_pc = fix(bus.trap_vec); m_dvld = 0; m_pend = 0;
        end else if (bus.redirect_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (bus.redirect_pc[1:0] != 0) m_mis = 1;
            else m_pc = bus.redirect_pc;
`else
            m_pc = fix(bus.redirect_pc);
`endif
            m_dvld = 0; m_pend = 0;
        end else begin
            if (a) m_pc = old_pc + 32'd4;
            m_pend = v && !bus.imem_req_ready;
            if (!bus.stall) begin
                m_dvld = a;
                if (a) m_dpc = old_pc;
            end
        end
    endtask

    // Inputs are already driven; check the combinational request, clock, then check state.
    task automatic step();
        #1;
        if (m_known) chk("req_valid", bus.imem_req_valid, m_valid());
        model_edge();
        @(posedge clk);
        #1;
        chk("pc_out", bus.pc_out, m_pc);
        chk("pc_d_valid", bus.pc_d_valid, m_dvld);
        if (m_dvld) chk("pc_d", bus.pc_d, m_dpc);
`ifdef PC_MISALIGN_TRAP_EN
        chk("misalign", bus.misalign, m_mis);
`endif
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.trap_valid = 0; bus.trap_vec = 0; bus.imem_req_ready = 1;
    endtask

    initial begin
        logic [31:0] pc_before;
        m_known = 0;
        rst = 1;
        idle_inputs();
        @(negedge clk);

        // Reset for two cycles
        step(); step();
        chk("rst_pc", bus.pc_out, RV);
        chk("rst_pc_d", bus.pc_d, 32'h0);
        chk("rst_boot_valid", bus.imem_req_valid, 1'b0);

        // Release: BOOT for one cycle, then fetch from the reset vector
        rst = 0;
        step();
        chk("boot_pc", bus.pc_out, 32'h100);
        chk("run_valid", bus.imem_req_valid, 1'b1);
        step();
        chk("seq_pc1", bus.pc_out, 32'h104);
        chk("seq_pcd1", bus.pc_d, 32'h100);
        step();
        chk("seq_pc2", bus.pc_out, 32'h108);
        chk("seq_pcd2", bus.pc_d, 32'h104);

        // Backpressure at 0x108
        bus.imem_req_ready = 0;
        repeat (3) step();
        chk("bp_pc", bus.pc_out, 32'h108);
        chk("bp_dvld", bus.pc_d_valid, 1'b0);
        bus.imem_req_ready = 1;
        step();
        chk("bp_release_pc", bus.pc_out, 32'h10C);
        chk("bp_release_pcd", bus.pc_d, 32'h108);
        step();

        // Trap beats redirect
        bus.trap_valid = 1; bus.trap_vec = 32'h80;
        bus.redirect_valid = 1; bus.redirect_pc = 32'h200;
        step();
        chk("trap_pc", bus.pc_out, 32'h80);
        chk("trap_flush", bus.pc_d_valid, 1'b0);
        idle_inputs();
        step();

        // Misaligned redirect
        pc_before = bus.pc_out;
        bus.redirect_valid = 1; bus.redirect_pc = 32'h202;
        step();
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_pc_held", bus.pc_out, pc_before);
        chk("mis_flag", bus.misalign, 1'b1);
`else
        chk("mis_aligned_pc", bus.pc_out, 32'h200);
`endif
        idle_inputs();
        bus.imem_req_ready = 0;
        step();
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_flag_clear", bus.misalign, 1'b0);
`endif

        // Wrap past 2^32, then stall
        bus.imem_req_ready = 1;
        bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 0;
        step();
        chk("wrap_pc", bus.pc_out, 32'h0);
        chk("wrap_pcd", bus.pc_d, 32'hFFFF_FFFC);
        bus.stall = 1;
        step(); step();
        chk("stall_pc", bus.pc_out, 32'h0);
        chk("stall_pcd", bus.pc_d, 32'hFFFF_FFFC);
        chk("stall_dvld", bus.pc_d_valid, 1'b1);
        chk("stall_valid", bus.imem_req_valid, 1'b0);
        bus.stall = 0;

        // Reset from WAIT, and reset during a redirect
        bus.imem_req_ready = 0;
        step();
        rst = 1;
        step();
        chk("wait_rst_pc", bus.pc_out, RV);
        rst = 0; bus.imem_req_ready = 1;
        step(); step();
        rst = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h400;
        step();
        chk("redir_rst_pc", bus.pc_out, RV);
        chk("redir_rst_dvld", bus.pc_d_valid, 1'b0);
        rst = 0;
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst                = ($urandom_range(0, 99) < 2);
            bus.stall          = ($urandom_range(0, 99) < 20);
            bus.imem_req_ready = ($urandom_range(0, 99) < 65);
            bus.trap_valid     = ($urandom_range(0, 99) < 5);
            bus.trap_vec       = $urandom;
            bus.redirect_valid = ($urandom_range(0, 99) < 10);
            bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + ($urandom & 32'h7)
                                                             : $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
